// File: rtl/timer_pkg.sv
// timer_pkg: shared types and helpers for the multi-channel tick timer.
package timer_pkg;
   typedef enum logic [1:0] {MODE_OFF, MODE_ONESHOT, MODE_PERIODIC, MODE_PWM} timer_mode_t;
   function automatic int pcnt_width(input int div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction
   // Output level when a channel (re)loads its config; phase is the periodic level to take.
   function automatic logic load_out(input timer_mode_t m, input logic duty_nz, input logic phase);
      return (m == MODE_PWM) ? duty_nz : (m == MODE_PERIODIC) ? phase : (m == MODE_ONESHOT);
   endfunction
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one channel's config shadow, tick counter and output generation.
module timer_channel
   import timer_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             en,
   input  logic             start,
   input  timer_mode_t      mode,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] duty,
   output logic             out,
   output logic             done,
   output logic             busy
);
   timer_mode_t      mode_q;
   logic [CNT_W-1:0] period_q, duty_q, cnt;
   logic             valid_in, valid_q, wrap;
   assign valid_in = (mode != MODE_OFF) && (period != '0);
   assign valid_q  = (mode_q != MODE_OFF) && (period_q != '0);
   assign wrap     = tick && (cnt == period_q - 1'b1);
   // Priority: disable, then restart, then idle, then wrap/expiry, then plain counting.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q   <= MODE_OFF;
         period_q <= '0;
         duty_q   <= '0;
         cnt      <= '0;
         out      <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!en || (!start && !(valid_q && busy))) begin
            cnt  <= '0;
            out  <= 1'b0;
            busy <= 1'b0;
         end else if (start || (wrap && mode_q != MODE_ONESHOT)) begin
            mode_q   <= mode;
            period_q <= period;
            duty_q   <= duty;
            cnt      <= '0;
            busy     <= valid_in;
            out      <= valid_in && load_out(mode, duty != '0, start || !out);
            done     <= !start;
         end else if (wrap) begin
            cnt  <= '0;
            out  <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
         end else if (tick) begin
            cnt <= cnt + 1'b1;
            if (mode_q == MODE_PWM) out <= (cnt + 1'b1) < duty_q;
         end
      end
   end
endmodule

// File: rtl/multi_channel_timer.sv
// multi_channel_timer: shared prescaler producing a tick, feeding N_CH independent timer channels.
module multi_channel_timer
   import timer_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 1_000,
   parameter int N_CH    = 4,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_CH-1:0]       en,
   input  logic [N_CH-1:0]       start,
   input  logic [2*N_CH-1:0]     mode,
   input  logic [CNT_W*N_CH-1:0] period,
   input  logic [CNT_W*N_CH-1:0] duty,
   output logic                  tick,
   output logic [N_CH-1:0]       out,
   output logic [N_CH-1:0]       done,
   output logic [N_CH-1:0]       busy
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = pcnt_width(DIV);
   logic [PW-1:0] pcnt;
   assign tick = (pcnt == PW'(DIV - 1));
   always_ff @(posedge clk) begin
      if (reset) pcnt <= '0;
      else pcnt <= tick ? '0 : pcnt + 1'b1;
   end
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      timer_channel #(.CNT_W(CNT_W)) u_ch (
         .clk   (clk),
         .reset (reset),
         .tick  (tick),
         .en    (en[i]),
         .start (start[i]),
         .mode  (timer_mode_t'(mode[2*i +: 2])),
         .period(period[CNT_W*i +: CNT_W]),
         .duty  (duty[CNT_W*i +: CNT_W]),
         .out   (out[i]),
         .done  (done[i]),
         .busy  (busy[i])
      );
   end
endmodule
